// File: rtl/fcap_bank_if.sv
// fcap_bank_if: bundles the fcap_bank control inputs and per-channel outputs.
// master drives en/mode/i_in/v_pre; slave (the bank) drives vcap/vterm/upd/sat/upd_cnt.
interface fcap_bank_if #(
  parameter int NCH = 4,
  parameter int CW  = 16
);
  logic              en;
  logic [2*NCH-1:0]  mode;
  real               i_in  [NCH];
  real               v_pre [NCH];
  real               vcap  [NCH];
  real               vterm [NCH];
  logic [NCH-1:0]    upd;
  logic [NCH-1:0]    sat_hi;
  logic [NCH-1:0]    sat_lo;
  logic [CW*NCH-1:0] upd_cnt;

  modport master (
    output en, mode, i_in, v_pre,
    input  vcap, vterm, upd, sat_hi, sat_lo, upd_cnt
  );

  modport slave (
    input  en, mode, i_in, v_pre,
    output vcap, vterm, upd, sat_hi, sat_lo, upd_cnt
  );
endinterface

// File: rtl/fcap_bank.sv
// fcap_bank: clocked multi-channel real-valued capacitor model (integrate/discharge/preset/clamp).
// Ports: ck, rst_n (async, active low), bus = fcap_bank_if.slave (inputs en/mode/i_in/v_pre).
module fcap_bank #(
  parameter int  NCH  = 4,
  parameter real C    = 1e-9,
  parameter real RS   = 0.0,
  parameter real RDIS = 1e3,
  parameter real IC   = 0.0,
  parameter real TINC = 1e-9,
  parameter real VTOL = 1e-4,
  parameter real VMAX = 1.8,
  parameter real VMIN = 0.0,
  parameter int  CW   = 16
) (
  input  logic       ck,
  input  logic       rst_n,
  fcap_bank_if.slave bus
);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_SAT_HI,
    ST_SAT_LO
  } st_e;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_INTEG = 2'b01;
  localparam logic [1:0] M_DISCH = 2'b10;
  localparam logic [1:0] M_PRE   = 2'b11;

  localparam real GAIN = TINC / C;
  localparam real KRAW = TINC / (RDIS * C);
  localparam real KDIS = (KRAW > 1.0) ? 1.0 :
                         ((KRAW < 0.0) ? 0.0 : KRAW);
  // Tiny relative slack so that N sub-VTOL steps summing to
  // exactly VTOL still publish despite float rounding.
  localparam real VGATE = VTOL * (1.0 - 1e-9);
  localparam logic [CW-1:0] CMAX = '1;

  function automatic logic fin(input real x);
    return (x - x) == 0.0;
  endfunction

  function automatic real rabs(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  st_e st_q [NCH];
  st_e st_d [NCH];

  real vint_q  [NCH];
  real vint_d  [NCH];
  real vcap_q  [NCH];
  real vcap_d  [NCH];
  real vterm_q [NCH];
  real vterm_d [NCH];
  real vn_c    [NCH];
  real vcl_c   [NCH];

  logic [CW-1:0] cnt_q [NCH];
  logic [CW-1:0] cnt_d [NCH];

  logic [NCH-1:0] upd_q;
  logic [NCH-1:0] upd_d;
  logic [NCH-1:0] ok_c;
  logic [NCH-1:0] act_c;
  logic [NCH-1:0] hold_c;
  logic [NCH-1:0] integ_c;
  logic [NCH-1:0] dis_c;
  logic [NCH-1:0] pre_c;
  logic [NCH-1:0] hi_c;
  logic [NCH-1:0] lo_c;
  logic [NCH-1:0] ent_c;
  logic [NCH-1:0] pub_c;
  logic [NCH-1:0] sat_hi_o;
  logic [NCH-1:0] sat_lo_o;

  // Candidate value and clamp per channel.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      ok_c[k]    = fin(bus.i_in[k]) && fin(bus.v_pre[k]);
      act_c[k]   = bus.en && (st_q[k] != ST_LOAD) && ok_c[k];
      hold_c[k]  = bus.mode[2*k +: 2] == M_HOLD;
      integ_c[k] = bus.mode[2*k +: 2] == M_INTEG;
      dis_c[k]   = bus.mode[2*k +: 2] == M_DISCH;
      pre_c[k]   = bus.mode[2*k +: 2] == M_PRE;
      vn_c[k]    = vint_q[k];
      unique case (1'b1)
        hold_c[k]:  vn_c[k] = vint_q[k];
        integ_c[k]: vn_c[k] = vint_q[k] + bus.i_in[k] * GAIN;
        dis_c[k]:   vn_c[k] = vint_q[k] * (1.0 - KDIS);
        pre_c[k]:   vn_c[k] = bus.v_pre[k];
        default:    vn_c[k] = vint_q[k];
      endcase
      hi_c[k]  = vn_c[k] > VMAX;
      lo_c[k]  = vn_c[k] < VMIN;
      vcl_c[k] = hi_c[k] ? VMAX :
                 (lo_c[k] ? VMIN : vn_c[k]);
    end
  end

  // FSM next state.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      st_d[k] = st_q[k];
      if (st_q[k] == ST_LOAD) begin
        st_d[k] = ST_RUN;
      end else if (act_c[k]) begin
        if (hi_c[k]) begin
          st_d[k] = ST_SAT_HI;
        end else if (lo_c[k]) begin
          st_d[k] = ST_SAT_LO;
        end else begin
          st_d[k] = ST_RUN;
        end
      end
    end
  end

  // FSM outputs.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      sat_hi_o[k] = st_q[k] == ST_SAT_HI;
      sat_lo_o[k] = st_q[k] == ST_SAT_LO;
    end
  end

  // Publish gate, outputs and counters.
  always_comb begin
    for (int k = 0; k < NCH; k++) begin
      vint_d[k]  = vint_q[k];
      vcap_d[k]  = vcap_q[k];
      vterm_d[k] = vterm_q[k];
      cnt_d[k]   = cnt_q[k];
      upd_d[k]   = 1'b0;
      ent_c[k]   = 1'b0;
      pub_c[k]   = 1'b0;
      if (act_c[k]) begin
        ent_c[k] = (st_d[k] != st_q[k]) &&
                   ((st_d[k] == ST_SAT_HI) ||
                    (st_d[k] == ST_SAT_LO));
        pub_c[k] = (rabs(vcl_c[k] - vcap_q[k]) >= VGATE) ||
                   pre_c[k] || ent_c[k];
        vint_d[k] = vcl_c[k];
        if (pub_c[k] && (vcl_c[k] != vcap_q[k])) begin
          vcap_d[k] = vcl_c[k];
          upd_d[k]  = 1'b1;
          if (cnt_q[k] != CMAX) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
          end
        end
        vterm_d[k] = integ_c[k] ?
                     vcap_d[k] + bus.i_in[k] * RS :
                     vcap_d[k];
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k] <= ST_LOAD;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= '0;
      for (int k = 0; k < NCH; k++) begin
        vint_q[k]  <= IC;
        vcap_q[k]  <= IC;
        vterm_q[k] <= IC;
        cnt_q[k]   <= '0;
      end
    end else begin
      upd_q <= upd_d;
      for (int k = 0; k < NCH; k++) begin
        vint_q[k]  <= vint_d[k];
        vcap_q[k]  <= vcap_d[k];
        vterm_q[k] <= vterm_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

  always @(posedge ck) begin
    for (int k = 0; k < NCH; k++) begin
      if (rst_n && bus.en && (st_q[k] != ST_LOAD) && !ok_c[k]) begin
        $warning("fcap_bank ch%0d: non-finite input, holding", k);
      end
    end
  end

  assign bus.upd    = upd_q;
  assign bus.sat_hi = sat_hi_o;
  assign bus.sat_lo = sat_lo_o;

  for (genvar g = 0; g < NCH; g++) begin : g_out
    assign bus.vcap[g]            = vcap_q[g];
    assign bus.vterm[g]           = vterm_q[g];
    assign bus.upd_cnt[CW*g +: CW] = cnt_q[g];
  end

endmodule
